// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

  localparam int SAMPLE               = 16;
  localparam int UART_CELL_TOTAL_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, 16 clocks per bit; start bit on the line 1 clock after accept.
// One-entry holding register: tx_ready drops while it is full and the held byte is never overwritten.
import uart_pkg::*;

module uart_transmitter #(
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TxBit,
  output logic       tx_busy,
  output logic       tx_done_signal
);

  localparam logic [3:0] LAST_SAMPLE = 4'(SAMPLE - 1);

  uart_state_t state, state_nxt;
  logic [3:0]  sample_cnt, sample_cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift_reg, shift_nxt;
  logic [7:0]  hold_dat;
  logic        hold_full, hold_full_nxt;
  logic        load_hold;
  logic        accept;
  logic        bit_end;
  logic        done_nxt;
  logic        tx_bit_nxt;

  assign accept  = tx_valid & tx_ready;
  assign bit_end = (sample_cnt == LAST_SAMPLE);
  assign tx_busy = (state != IDLE);

  always_comb begin
    state_nxt      = state;
    sample_cnt_nxt = sample_cnt + 4'd1;
    bit_idx_nxt    = bit_idx;
    shift_nxt      = shift_reg;
    load_hold      = 1'b0;
    done_nxt       = 1'b0;
    tx_bit_nxt     = 1'b1;

    case (state)
      IDLE: begin
        sample_cnt_nxt = 4'd0;
        if (hold_full) begin
          state_nxt = START;
          load_hold = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shift_nxt   = {1'b0, shift_reg[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          done_nxt = 1'b1;
          // A waiting byte starts immediately so frames abut with no idle gap.
          if (hold_full) begin
            state_nxt = START;
            load_hold = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load_hold) begin
      shift_nxt = hold_dat;
    end

    // accept and load_hold are exclusive: accept needs holding empty, load needs it full.
    if (accept) begin
      hold_full_nxt = 1'b1;
    end else if (load_hold) begin
      hold_full_nxt = 1'b0;
    end else begin
      hold_full_nxt = hold_full;
    end

    case (state_nxt)
      START:   tx_bit_nxt = 1'b0;
      DATA:    tx_bit_nxt = shift_nxt[0];
      default: tx_bit_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sample_cnt     <= 4'd0;
      bit_idx        <= 3'd0;
      shift_reg      <= 8'd0;
      hold_dat       <= 8'd0;
      hold_full      <= 1'b0;
      tx_ready       <= 1'b0;
      TxBit          <= 1'b1;
      tx_done_signal <= 1'b0;
    end else begin
      state          <= state_nxt;
      sample_cnt     <= sample_cnt_nxt;
      bit_idx        <= bit_idx_nxt;
      shift_reg      <= shift_nxt;
      hold_full      <= hold_full_nxt;
      tx_ready       <= ~hold_full_nxt;
      TxBit          <= tx_bit_nxt;
      tx_done_signal <= done_nxt;
      if (accept) begin
        hold_dat <= tx_data;
      end
    end
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 115200, documentary only; clk frequency is BAUD_RATE * 16.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port: clk  input  1  rising-edge clock, 16 clocks per UART bit.
REQ-004 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port: tx_data  input  8  byte to send, LSB transmitted first.
REQ-006 SHALL have port: tx_valid  input  1  tx_data is valid this cycle.
REQ-007 SHALL have port: tx_ready  output  1  holding register empty; byte accepted when tx_valid & tx_ready at a clock edge.
REQ-008 SHALL have port: TxBit  output  1  serial line, registered, idles high.
REQ-009 SHALL have port: tx_busy  output  1  a frame is on the line (any state other than IDLE).
REQ-010 SHALL have port: tx_done_signal  output  1  one-cycle pulse when a 10-bit frame completes.

Function
REQ-011 SHALL send each frame as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), each held exactly 16 clocks, for 160 clocks per frame.
REQ-012 SHALL implement states IDLE, START, DATA, STOP:
- a 4-bit sample counter counts 0..15 within each bit;
- a 3-bit bit index counts 0..7 in DATA.
REQ-013 SHALL sequence states as follows:
- IDLE to START at the edge after which the holding register is full;
- START to DATA when sample counter = 15;
- DATA to STOP when sample counter = 15 and bit index = 7;
- STOP to IDLE, or directly to START (REQ-016), when sample counter = 15.
REQ-014 SHALL use a one-entry holding register:
- tx_ready = not holding-full, driven from a register;
- on accept, the byte is captured, and tx_data may change on the following cycle.
REQ-015 SHALL drive TxBit low one clock after the accept edge when the block is IDLE with holding empty; latency from accept to start bit is 1 cycle.
REQ-016 SHALL behave as follows at the final STOP cycle when holding is full:
- move directly to START with no idle gap between frames;
- load the shift register and free the holding register at that same edge;
- raise tx_ready on the next cycle.
REQ-017 SHALL NOT accept a byte while holding is full; the held byte SHALL NOT be overwritten, regardless of tx_valid.
REQ-018 SHALL accept a new byte into holding during START, DATA or STOP (holding empty) without disturbing the frame in progress.
REQ-019 SHALL assert tx_done_signal for exactly one cycle, registered at the edge that ends the STOP bit, including back-to-back frames.
REQ-020 SHALL keep TxBit high in IDLE; TxBit SHALL never glitch, since it is a flop output.
REQ-021 SHALL let the sample counter wrap 15 to 0 at every bit boundary; the bit index SHALL reset to 0 on entry to DATA.

Reset
REQ-022 SHALL, at a clk edge with rst = 1, set: state IDLE, TxBit 1, tx_busy 0, tx_done_signal 0, holding empty, both counters 0, shift register 0.
REQ-023 SHALL drive tx_ready 0 while rst is asserted and 1 on the first cycle after rst deasserts.
REQ-024 SHALL, on reset mid-frame, abandon the frame:
- TxBit returns high at that edge;
- the held byte is discarded;
- no tx_done_signal is emitted.

Structure
REQ-025 SHALL take SAMPLE = 16, UART_CELL_TOTAL_BITS = 10 and the state encoding from shared package uart_pkg, which uart_receiver also uses.
REQ-026 SHALL be a single module with no sub-module; the bit-timing counter is inline.

Verification
REQ-027 SHALL verify single byte: send 0xA5 after idle.
- TxBit reads 0,1,0,1,0,0,1,0,1,1, each value held for 16 clocks.
- tx_done_signal pulses once, 160 clocks after the start bit begins.
REQ-028 SHALL verify back-to-back: tx_valid held with 0x55 then 0x0F.
- Two frames are sent with no idle gap, 320 clocks total.
- Two done pulses occur, 160 clocks apart.
- tx_ready is low between the second accept and the first stop end.
REQ-029 SHALL verify backpressure: with holding full, tx_valid is asserted with 0xFF.
- tx_ready stays 0.
- 0xFF is not sent until it is accepted after holding frees.
REQ-030 SHALL verify reset mid-frame: assert rst during data bit 3 of 0x3C.
- TxBit is 1 at the next edge and tx_busy is 0.
- No done pulse occurs.
- The next byte, 0x81, frames correctly.
REQ-031 SHALL verify loopback: TxBit drives uart_receiver.RxBit with bytes 0x00, 0xFF, 0x3C.
- RxData matches each byte.
- rx_done_signal fires once per byte.
